// File: rtl/sec02_pair_packer_if.sv
// Valid/ready word stream; the producer drives val/msg, the consumer drives rdy.
// A transfer happens on a clock edge where val and rdy are both high.
interface sec02_pair_packer_if #(
    parameter int p_nbits = 32
);
    logic               val;
    logic               rdy;
    logic [p_nbits-1:0] msg;

    modport master (output val, output msg, input  rdy);
    modport slave  (input  val, input  msg, output rdy);
endinterface

// File: rtl/sec02_pair_packer.sv
// Packs consecutive input words into {first, second} pairs; pair valid 1 cycle after the second word.
// Ready/valid are pure state decodes; input stalls only while a pair and the next first word are both held.
module sec02_pair_packer #(
    parameter int p_nbits     = 32,
    parameter int p_cnt_nbits = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    sec02_pair_packer_if.slave     istream,
    sec02_pair_packer_if.master    ostream,
    output logic [p_cnt_nbits-1:0] pair_count
);

    typedef enum logic [1:0] {
        ST_EMPTY     = 2'd0,
        ST_HALF      = 2'd1,
        ST_FULL      = 2'd2,
        ST_FULL_HALF = 2'd3
    } state_t;

    state_t               state;
    logic [p_nbits-1:0]   first_word;
    logic [2*p_nbits-1:0] pair;
    logic                 in_rdy;
    logic                 out_val;
    logic                 in_xfer;
    logic                 out_xfer;

    assign in_xfer     = istream.val & in_rdy;
    assign out_xfer    = out_val & ostream.rdy;
    assign istream.rdy = in_rdy;
    assign ostream.val = out_val;
    assign ostream.msg = pair;

    // in_rdy/out_val are updated alongside state so they always equal its decode.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_EMPTY;
            in_rdy     <= 1'b1;
            out_val    <= 1'b0;
            pair_count <= '0;
            first_word <= '0;
            pair       <= '0;
        end else begin
            if (out_xfer) begin
                pair_count <= pair_count + p_cnt_nbits'(1);
            end
            case (state)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        first_word <= istream.msg;
                        state      <= ST_HALF;
                    end
                end
                ST_HALF: begin
                    if (in_xfer) begin
                        pair    <= {first_word, istream.msg};
                        state   <= ST_FULL;
                        out_val <= 1'b1;
                    end
                end
                ST_FULL: begin
                    case ({in_xfer, out_xfer})
                        2'b11: begin
                            first_word <= istream.msg;
                            state      <= ST_HALF;
                            out_val    <= 1'b0;
                        end
                        2'b10: begin
                            first_word <= istream.msg;
                            state      <= ST_FULL_HALF;
                            in_rdy     <= 1'b0;
                        end
                        2'b01: begin
                            state   <= ST_EMPTY;
                            out_val <= 1'b0;
                        end
                        default: ;
                    endcase
                end
                ST_FULL_HALF: begin
                    // The held word becomes the first word of the next pair.
                    if (out_xfer) begin
                        state   <= ST_HALF;
                        out_val <= 1'b0;
                        in_rdy  <= 1'b1;
                    end
                end
                default: begin
                    state   <= ST_EMPTY;
                    in_rdy  <= 1'b1;
                    out_val <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sec02_pair_packer.sv
// Randomized and directed bench for sec02_pair_packer against a queue-of-words reference model.
module tb_sec02_pair_packer;

    logic       clk;
    logic       reset;
    logic [1:0] pair_count;

    sec02_pair_packer_if #(.p_nbits(32)) in_if ();
    sec02_pair_packer_if #(.p_nbits(64)) out_if ();

    sec02_pair_packer #(.p_nbits(32), .p_cnt_nbits(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .istream    (in_if),
        .ostream    (out_if),
        .pair_count (pair_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: words accepted but not yet emitted, in arrival order.
    logic [31:0] q[$];
    logic [63:0] log_q[$];
    logic [1:0]  exp_cnt;
    int          n_chk;
    int          n_fail;
    logic        acc;
    logic [31:0] w[100];

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // Check current outputs against the model, then drive one cycle of stimulus.
    task automatic step(input logic v, input logic [31:0] m, input logic r, input logic rn,
                        output logic accepted);
        @(negedge clk);
        chk("istream_rdy", 64'(in_if.rdy), 64'(q.size() < 3));
        chk("ostream_val", 64'(out_if.val), 64'(q.size() >= 2));
        chk("pair_count", 64'(pair_count), 64'(exp_cnt));
        if (q.size() >= 2) chk("ostream_msg", out_if.msg, {q[0], q[1]});
        in_if.val  = v;
        in_if.msg  = m;
        out_if.rdy = r;
        reset      = rn;
        accepted   = 1'b0;
        if (!rn) begin
            q.delete();
            exp_cnt = 2'd0;
        end else begin
            if (out_if.val && r) log_q.push_back(out_if.msg);
            if (q.size() >= 2 && r) begin
                void'(q.pop_front());
                void'(q.pop_front());
                exp_cnt = exp_cnt + 2'd1;
            end
            if (v && in_if.rdy) begin
                q.push_back(m);
                accepted = 1'b1;
            end
        end
    endtask

    task automatic send(input logic [31:0] m, input logic r);
        logic a;
        step(1'b1, m, r, 1'b1, a);
    endtask

    task automatic idle(input logic r);
        logic a;
        step(1'b0, 32'd0, r, 1'b1, a);
    endtask

    task automatic rst_cycle();
        logic a;
        step(1'b0, 32'd0, 1'b0, 1'b0, a);
        log_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] basic[6];
        int          idx;
        int          guard;
        n_chk      = 0;
        n_fail     = 0;
        exp_cnt    = 2'd0;
        in_if.val  = 1'b0;
        in_if.msg  = 32'd0;
        out_if.rdy = 1'b0;
        reset      = 1'b0;
        repeat (2) @(posedge clk);

        // Basic pairing
        basic = '{32'd1, 32'd1, 32'd2, 32'd2, 32'd4, 32'd5};
        foreach (basic[i]) send(basic[i], 1'b1);
        idle(1'b1);
        idle(1'b1);
        chk("basic_npairs", 64'(log_q.size()), 64'd3);
        chk("basic_p0", log_q[0], {32'd1, 32'd1});
        chk("basic_p1", log_q[1], {32'd2, 32'd2});
        chk("basic_p2", log_q[2], {32'd4, 32'd5});
        chk("basic_cnt", 64'(pair_count), 64'd3);

        // Full throughput
        rst_cycle();
        for (int i = 0; i < 8; i++) send(32'(i), 1'b1);
        idle(1'b1);
        idle(1'b1);
        chk("thru_npairs", 64'(log_q.size()), 64'd4);
        for (int k = 0; k < 4; k++) chk("thru_pair", log_q[k], {32'(2*k), 32'(2*k+1)});

        // Backpressure into FULL_HALF
        rst_cycle();
        send(32'hA, 1'b0);
        send(32'hB, 1'b0);
        send(32'hC, 1'b0);
        idle(1'b0);
        idle(1'b0);
        chk("bp_rdy_low", 64'(in_if.rdy), 64'd0);
        chk("bp_msg_hold", out_if.msg, {32'hA, 32'hB});
        send(32'hD, 1'b1);
        send(32'hD, 1'b1);
        idle(1'b1);
        idle(1'b1);
        chk("bp_npairs", 64'(log_q.size()), 64'd2);
        chk("bp_p0", log_q[0], {32'hA, 32'hB});
        chk("bp_p1", log_q[1], {32'hC, 32'hD});

        // Reset mid-operation, with an input offered during reset
        rst_cycle();
        send(32'd9, 1'b1);
        step(1'b1, 32'd7, 1'b1, 1'b0, acc);
        log_q.delete();
        send(32'd3, 1'b1);
        send(32'd4, 1'b1);
        idle(1'b1);
        idle(1'b1);
        chk("rst_npairs", 64'(log_q.size()), 64'd1);
        chk("rst_pair", log_q[0], {32'd3, 32'd4});

        // Counter wrap on a 2-bit counter: 5 pairs -> 1
        rst_cycle();
        for (int i = 0; i < 10; i++) send(32'(100 + i), 1'b1);
        idle(1'b1);
        idle(1'b1);
        chk("wrap_cnt", 64'(pair_count), 64'd1);

        // Random source and sink delays
        rst_cycle();
        foreach (w[i]) w[i] = $urandom;
        idx   = 0;
        guard = 0;
        while (idx < 100 && guard < 5000) begin
            step(($urandom_range(0, 3) != 0), w[idx], ($urandom_range(0, 2) != 0), 1'b1, acc);
            if (acc) idx++;
            guard++;
        end
        chk("rand_accepted", 64'(idx), 64'd100);
        repeat (10) idle(1'b1);
        chk("rand_npairs", 64'(log_q.size()), 64'd50);
        for (int k = 0; k < 50; k++) chk("rand_pair", log_q[k], {w[2*k], w[2*k+1]});

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
